alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  input  1  Rising-edge clock for the status register.
REQ-003 rst  input  1  Asynchronous active-high reset of the status register.
REQ-004 aluop1, aluop0  input  1 each  ALU operation class from the main control.
REQ-005 funct  input  5  Instruction bits [4:0].
REQ-006 a, b  input  32 each  ALU operands; a = read data 1, b = ALUSrc mux output.
REQ-007 pc  input  32  Current program counter.
REQ-008 imm16  input  16  Instruction bits [15:0], the branch offset in words.
REQ-009 status_we  input  1  Status register write enable.
REQ-010 gout  output  3  ALU control code.
REQ-011 result  output  32  ALU result.
REQ-012 zout  output  1  High when result equals 0.
REQ-013 status  output  3  Combinational flags {Z, N, V}.
REQ-014 status_reg  output  3  Registered flags {Z, N, V}.
REQ-015 pc_plus4  output  32  Value of pc + 4.
REQ-016 branch_target  output  32  Value of pc_plus4 + (sign-extended imm16 << 2).

Function
REQ-017 ALU control decode SHALL be as follows.
- {aluop1, aluop0} = 00: gout = 010 (ADD).
- {aluop1, aluop0} = 01 or 11: gout = 110 (SUB).
- {aluop1, aluop0} = 10: gout is decoded from funct[3:0].
REQ-018 The funct[3:0] decode for aluop = 10 SHALL be: 0000 -> 010 ADD, 0010 -> 110 SUB, 0100 -> 000 AND, 0101 -> 001 OR, 0111 -> 011 NOR, 1010 -> 111 SLT, and any other value -> 010 ADD.
- funct[4] is ignored.
REQ-019 The ALU SHALL implement each gout code as follows.
- 000: a & b.
- 001: a | b.
- 011: ~(a | b).
- 010: a + b.
- 110: a - b.
- 111: 32'd1 if a < b as signed values, else 0.
- 100, 101: result 0.
REQ-020 Add and sub SHALL be computed modulo 2^32 with no exception.
REQ-021 SLT SHALL compare correctly when a - b overflows, i.e. it uses sign(a - b) XOR V.
REQ-022 The flags SHALL be defined as follows.
- Z (status[2]) = (result == 0).
- N (status[1]) = result[31].
- V (status[0]) = signed overflow for ADD and SUB, and 0 for every other operation.
REQ-023 zout SHALL equal status[2].
REQ-024 gout, result, zout, status, pc_plus4 and branch_target SHALL be purely combinational, with zero-cycle latency.
REQ-025 pc_plus4 SHALL equal pc + 4 modulo 2^32.
REQ-026 branch_target SHALL equal pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00} modulo 2^32.
REQ-027 On each rising clk edge, status_reg SHALL load status if status_we = 1, and otherwise hold its value.
- The registered value appears one cycle after the write.
REQ-028 If rst and a clk edge coincide, rst SHALL win.

Reset
REQ-029 When rst is asserted, status_reg SHALL go to 3'b000 immediately, independent of clk.
REQ-030 status_reg SHALL hold 3'b000 while rst is high.
REQ-031 Combinational outputs SHALL be unaffected by rst.
REQ-032 Asserting rst while status_we = 1 SHALL discard the pending write.

Verification
REQ-033 The bench SHALL cover the following directed scenarios.
- aluop = 10, funct = 00000, a = 7FFFFFFF, b = 1 -> gout 010, result 80000000, status {0,1,1}.
- aluop = 01, a = 5, b = 5 -> gout 110, result 0, zout 1, status {1,0,0}.
- aluop = 10, funct = 01010, a = 80000000, b = 1 -> gout 111, result 1 (signed SLT despite sub overflow).
- aluop = 10, funct = 00100 then 00101 then 00111, a = F0F0F0F0, b = 0FF00FF0 -> AND 00F000F0, OR FFF0FFF0, NOR 000F000F; V = 0 in all three.
- pc = 00000008, imm16 = FFFF -> pc_plus4 0000000C, branch_target 00000008; pc = FFFFFFFC -> pc_plus4 00000000 (wrap-around).
- Status register sequence:
  - status_we = 1 with result 0 -> status_reg = 100 after the next rising edge;
  - status_we = 0 -> the value holds;
  - async rst pulse between edges -> status_reg = 000 immediately.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Single-cycle execute stage: ALU control decode, 32-bit ALU with {Z,N,V} flags,
// a registered status copy, and PC+4 / branch-target adders.
module alu_exec_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              aluop1,
    input  logic              aluop0,
    input  logic [4:0]        funct,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [31:0]       pc,
    input  logic [15:0]       imm16,
    input  logic              status_we,
    output logic [2:0]        gout,
    output logic [DATA_W-1:0] result,
    output logic              zout,
    output logic [2:0]        status,
    output logic [2:0]        status_reg,
    output logic [31:0]       pc_plus4,
    output logic [31:0]       branch_target
);

    localparam logic [2:0] G_AND = 3'b000;
    localparam logic [2:0] G_OR  = 3'b001;
    localparam logic [2:0] G_ADD = 3'b010;
    localparam logic [2:0] G_NOR = 3'b011;
    localparam logic [2:0] G_SUB = 3'b110;
    localparam logic [2:0] G_SLT = 3'b111;

    // funct[4] is deliberately ignored; unlisted R-type codes fall back to ADD.
    function automatic logic [2:0] decode_alu_ctl(input logic [1:0] op, input logic [3:0] fn);
        logic [2:0] g;
        g = G_ADD;
        case (op)
            2'b00: g = G_ADD;
            2'b01,
            2'b11: g = G_SUB;
            default: begin
                case (fn)
                    4'b0000: g = G_ADD;
                    4'b0010: g = G_SUB;
                    4'b0100: g = G_AND;
                    4'b0101: g = G_OR;
                    4'b0111: g = G_NOR;
                    4'b1010: g = G_SLT;
                    default: g = G_ADD;
                endcase
            end
        endcase
        return g;
    endfunction

    function automatic logic add_overflow(input logic sa, input logic sb, input logic ss);
        return (sa == sb) && (ss != sa);
    endfunction

    function automatic logic sub_overflow(input logic sa, input logic sb, input logic sd);
        return (sa != sb) && (sd != sa);
    endfunction

    logic [2:0]        w_gout;
    logic signed [DATA_W-1:0] w_sum;
    logic signed [DATA_W-1:0] w_diff;
    logic              w_v_add;
    logic              w_v_sub;
    logic              w_slt;
    logic [DATA_W-1:0] w_result;
    logic              w_v;
    logic [2:0]        w_status;
    logic [31:0]       w_pc_plus4;
    logic [31:0]       w_offset;
    logic [2:0]        r_status;

    assign w_gout  = decode_alu_ctl({aluop1, aluop0}, funct[3:0]);
    assign w_sum   = $signed(a) + $signed(b);
    assign w_diff  = $signed(a) - $signed(b);
    assign w_v_add = add_overflow(a[DATA_W-1], b[DATA_W-1], w_sum[DATA_W-1]);
    assign w_v_sub = sub_overflow(a[DATA_W-1], b[DATA_W-1], w_diff[DATA_W-1]);
    // Sign of the difference corrected by overflow gives the true signed less-than.
    assign w_slt   = w_diff[DATA_W-1] ^ w_v_sub;

    always_comb begin
        w_result = '0;
        w_v      = 1'b0;
        case (w_gout)
            G_AND: w_result = a & b;
            G_OR:  w_result = a | b;
            G_NOR: w_result = ~(a | b);
            G_ADD: begin
                w_result = w_sum;
                w_v      = w_v_add;
            end
            G_SUB: begin
                w_result = w_diff;
                w_v      = w_v_sub;
            end
            G_SLT: w_result = {{(DATA_W-1){1'b0}}, w_slt};
            default: w_result = '0;
        endcase
    end

    assign w_status   = {(w_result == '0), w_result[DATA_W-1], w_v};
    assign w_pc_plus4 = pc + 32'd4;
    assign w_offset   = {{14{imm16[15]}}, imm16, 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status <= 3'b000;
        end else if (status_we) begin
            r_status <= w_status;
        end
    end

    assign gout          = w_gout;
    assign result        = w_result;
    assign zout          = w_status[2];
    assign status        = w_status;
    assign status_reg    = r_status;
    assign pc_plus4      = w_pc_plus4;
    assign branch_target = w_pc_plus4 + w_offset;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed vector table for the combinational path plus hand sequences for the status register.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst;
    logic        aluop1, aluop0;
    logic [4:0]  funct;
    logic [31:0] a, b, pc;
    logic [15:0] imm16;
    logic        status_we;
    logic [2:0]  gout;
    logic [31:0] result;
    logic        zout;
    logic [2:0]  status;
    logic [2:0]  status_reg;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;

    int checks = 0;
    int errors = 0;

    alu_exec_unit dut (
        .clk(clk), .rst(rst), .aluop1(aluop1), .aluop0(aluop0), .funct(funct),
        .a(a), .b(b), .pc(pc), .imm16(imm16), .status_we(status_we),
        .gout(gout), .result(result), .zout(zout), .status(status),
        .status_reg(status_reg), .pc_plus4(pc_plus4), .branch_target(branch_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [4:0]  fn;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] vpc;
        logic [15:0] vimm;
        logic [2:0]  e_gout;
        logic [31:0] e_result;
        logic        e_zout;
        logic [2:0]  e_status;
        logic [31:0] e_pc4;
        logic [31:0] e_bt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [4:0] fn,
                         input logic [31:0] va, input logic [31:0] vb);
        {aluop1, aluop0} = op;
        funct = fn;
        a = va;
        b = vb;
    endtask

    initial begin
        rst = 1'b1;
        status_we = 1'b0;
        drive(2'b00, 5'd0, 32'd0, 32'd0);
        pc = 32'd0;
        imm16 = 16'd0;

        //                name          op     funct     a             b             pc            imm       gout    result        z     status  pc4           bt
        vecs.push_back('{"add_ovf",     2'b10, 5'b00000, 32'h7FFFFFFF, 32'h00000001, 32'h00000008, 16'hFFFF, 3'b010, 32'h80000000, 1'b0, 3'b011, 32'h0000000C, 32'h00000008});
        vecs.push_back('{"sub_zero",    2'b01, 5'b00000, 32'h00000005, 32'h00000005, 32'hFFFFFFFC, 16'h0000, 3'b110, 32'h00000000, 1'b1, 3'b100, 32'h00000000, 32'h00000000});
        vecs.push_back('{"slt_ovf",     2'b10, 5'b01010, 32'h80000000, 32'h00000001, 32'h00000100, 16'h0001, 3'b111, 32'h00000001, 1'b0, 3'b000, 32'h00000104, 32'h00000108});
        vecs.push_back('{"and",         2'b10, 5'b00100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00000000, 16'h7FFF, 3'b000, 32'h00F000F0, 1'b0, 3'b000, 32'h00000004, 32'h00020000});
        vecs.push_back('{"or",          2'b10, 5'b00101, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00000000, 16'h8000, 3'b001, 32'hFFF0FFF0, 1'b0, 3'b010, 32'h00000004, 32'hFFFE0004});
        vecs.push_back('{"nor",         2'b10, 5'b00111, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00000010, 16'hFFFE, 3'b011, 32'h000F000F, 1'b0, 3'b000, 32'h00000014, 32'h0000000C});
        vecs.push_back('{"aluop00_add", 2'b00, 5'b00111, 32'h00000003, 32'h00000004, 32'h00001000, 16'h0010, 3'b010, 32'h00000007, 1'b0, 3'b000, 32'h00001004, 32'h00001044});
        vecs.push_back('{"aluop11_sub", 2'b11, 5'b00100, 32'h00000003, 32'h00000005, 32'h00000000, 16'h0000, 3'b110, 32'hFFFFFFFE, 1'b0, 3'b010, 32'h00000004, 32'h00000004});
        vecs.push_back('{"funct_dflt",  2'b10, 5'b01111, 32'h00000002, 32'h00000003, 32'h00000000, 16'h0000, 3'b010, 32'h00000005, 1'b0, 3'b000, 32'h00000004, 32'h00000004});
        vecs.push_back('{"funct4_ign",  2'b10, 5'b10010, 32'h00000009, 32'h00000004, 32'h00000000, 16'h0000, 3'b110, 32'h00000005, 1'b0, 3'b000, 32'h00000004, 32'h00000004});
        vecs.push_back('{"sub_ovf",     2'b01, 5'b00000, 32'h80000000, 32'h00000001, 32'h00000000, 16'h0000, 3'b110, 32'h7FFFFFFF, 1'b0, 3'b001, 32'h00000004, 32'h00000004});
        vecs.push_back('{"slt_false",   2'b10, 5'b01010, 32'h00000005, 32'h00000003, 32'h00000000, 16'h0000, 3'b111, 32'h00000000, 1'b1, 3'b100, 32'h00000004, 32'h00000004});
        vecs.push_back('{"slt_ovf_f",   2'b10, 5'b01010, 32'h00000001, 32'h80000000, 32'h00000000, 16'h0000, 3'b111, 32'h00000000, 1'b1, 3'b100, 32'h00000004, 32'h00000004});
        vecs.push_back('{"slt_neg",     2'b10, 5'b01010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 16'h0000, 3'b111, 32'h00000001, 1'b0, 3'b000, 32'h00000004, 32'h00000004});
        vecs.push_back('{"add_wrap0",   2'b00, 5'b00000, 32'h80000000, 32'h80000000, 32'h00000000, 16'h0000, 3'b010, 32'h00000000, 1'b1, 3'b101, 32'h00000004, 32'h00000004});

        // Reset state, with rst asserted asynchronously before any clock edge
        #2;
        chk("status_reg_reset", {29'd0, status_reg}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].fn, vecs[i].va, vecs[i].vb);
            pc = vecs[i].vpc;
            imm16 = vecs[i].vimm;
            #1;
            chk({vecs[i].name, "_gout"},   {29'd0, gout},   {29'd0, vecs[i].e_gout});
            chk({vecs[i].name, "_result"}, result,          vecs[i].e_result);
            chk({vecs[i].name, "_zout"},   {31'd0, zout},   {31'd0, vecs[i].e_zout});
            chk({vecs[i].name, "_status"}, {29'd0, status}, {29'd0, vecs[i].e_status});
            chk({vecs[i].name, "_pc4"},    pc_plus4,        vecs[i].e_pc4);
            chk({vecs[i].name, "_bt"},     branch_target,   vecs[i].e_bt);
        end
        chk("status_reg_no_we", {29'd0, status_reg}, 32'd0);

        // Write a zero result into the status register
        @(negedge clk);
        drive(2'b01, 5'd0, 32'd5, 32'd5);
        status_we = 1'b1;
        #1;
        chk("status_reg_before_edge", {29'd0, status_reg}, 32'd0);
        @(posedge clk); #1;
        chk("status_reg_load_z", {29'd0, status_reg}, 32'h4);

        // Hold while write enable is low, even with different flags
        @(negedge clk);
        status_we = 1'b0;
        drive(2'b10, 5'b00000, 32'h7FFFFFFF, 32'd1);
        @(posedge clk); #1;
        chk("status_reg_hold", {29'd0, status_reg}, 32'h4);

        // Load overflow flags
        @(negedge clk);
        status_we = 1'b1;
        @(posedge clk); #1;
        chk("status_reg_load_nv", {29'd0, status_reg}, 32'h3);

        // Async reset pulse between edges clears immediately
        @(negedge clk);
        status_we = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("status_reg_async_rst", {29'd0, status_reg}, 32'd0);
        chk("result_during_rst", result, 32'h80000000);
        chk("status_during_rst", {29'd0, status}, 32'h3);
        rst = 1'b0;

        // Reset held across an edge with write pending discards the write
        @(negedge clk);
        status_we = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("status_reg_rst_beats_we", {29'd0, status_reg}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("status_reg_after_rst_release", {29'd0, status_reg}, 32'd0);
        @(posedge clk); #1;
        chk("status_reg_reload", {29'd0, status_reg}, 32'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
